// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: write-pointer synchronizer, read pointers,
// empty/level status and a show-ahead output register with valid/ready handshake.
module fifo_rd_ctrl #(
    parameter int unsigned PointerWidth = 4,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned AeThresh     = 2
) (
    input  logic                      rclk_i,
    input  logic                      rrst_i,
    input  logic [PointerWidth-1:0]   gray_wr_ptr_i,
    input  logic [DataWidth-1:0]      r_data_mem_i,
    output logic [PointerWidth-2:0]   r_addr_o,
    output logic                      r_en_o,
    output logic [PointerWidth-1:0]   gray_rd_ptr_o,
    output logic [DataWidth-1:0]      rd_data_o,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic                      rempty_o,
    output logic                      almost_empty_o,
    output logic [PointerWidth-1:0]   rd_level_o
);

    localparam int unsigned AddrWidth = PointerWidth - 1;
    localparam logic [31:0] AeThreshW = 32'(AeThresh);

    logic [PointerWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [PointerWidth-1:0] gray_rd_ptr_q, gray_rd_ptr_d;
    logic [PointerWidth-1:0] wq1_q, wq2_q;
    logic [DataWidth-1:0]    rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [PointerWidth-1:0] wbin;
    logic                    rempty;
    logic                    fetch;

    // Gray-to-binary on the synchronized write pointer: bit i is the XOR of bits MSB..i.
    always_comb begin
        wbin = '0;
        wbin[PointerWidth-1] = wq2_q[PointerWidth-1];
        for (int i = PointerWidth - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ wq2_q[i];
        end
    end

    assign rempty = (gray_rd_ptr_q == wq2_q);
    assign fetch  = !rempty && (!rd_valid_q || rd_ready_i);

    always_comb begin
        rd_ptr_d      = rd_ptr_q + {{AddrWidth{1'b0}}, fetch};
        gray_rd_ptr_d = rd_ptr_d ^ (rd_ptr_d >> 1);
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        if (fetch) begin
            rd_data_d  = r_data_mem_i;
            rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready_i) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            rd_ptr_q      <= '0;
            gray_rd_ptr_q <= '0;
            wq1_q         <= '0;
            wq2_q         <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            gray_rd_ptr_q <= gray_rd_ptr_d;
            wq1_q         <= gray_wr_ptr_i;
            wq2_q         <= wq1_q;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign r_addr_o       = rd_ptr_q[AddrWidth-1:0];
    assign r_en_o         = fetch;
    assign gray_rd_ptr_o  = gray_rd_ptr_q;
    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign rempty_o       = rempty;
    assign rd_level_o     = wbin - rd_ptr_q;
    assign almost_empty_o = (32'(rd_level_o) <= AeThreshW);

endmodule
